// File: rtl/p18_beep_detector.sv
// p18_beep_detector
// Listens to the p18 sound generator's square-wave line, measures each
// half-period in video lines and reports whether the high beep
// (2^(SOUND_DIVIDER-1) lines) or the low beep (2^SOUND_DIVIDER lines) is
// present. A tone is reported once two consecutive half-periods fall in the
// same tone window; the flag is then held for HOLD_FRAMES frames.
//
// Ports:
//   clk            system clock
//   nRst           asynchronous active-low reset
//   sound_in       asynchronous audio square wave
//   line_pulse     one-clk strobe per video line
//   frame_pulse    one-clk strobe per frame
//   high_beep_det  high tone present (held)
//   low_beep_det   low tone present (held)
//   high_start     one-clk pulse when high_beep_det rises
//   low_start      one-clk pulse when low_beep_det rises
module p18_beep_detector #(
  parameter int SOUND_DIVIDER = 5,
  parameter int TOLERANCE     = 2,
  parameter int HOLD_FRAMES   = 3
) (
  input  logic clk,
  input  logic nRst,
  input  logic sound_in,
  input  logic line_pulse,
  input  logic frame_pulse,
  output logic high_beep_det,
  output logic low_beep_det,
  output logic high_start,
  output logic low_start
);

  localparam int W = SOUND_DIVIDER + 2;
  localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
  localparam logic [W-1:0] HIGH_HP   = W'(2 ** (SOUND_DIVIDER - 1));
  localparam logic [W-1:0] LOW_HP    = W'(2 ** SOUND_DIVIDER);
  localparam logic [W-1:0] TOL_W     = W'(TOLERANCE);
  localparam logic [2:0]   HOLD_INIT = 3'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_HIGH = 2'd1,
    CLS_LOW  = 2'd2
  } cls_e;

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // Returns {det, hold}. A confirmation reloads and wins over a frame tick;
  // the flag drops on the tick that takes the counter from 1 to 0.
  function automatic logic [3:0] hold_next(input logic       confirm,
                                           input logic       frame,
                                           input logic       det,
                                           input logic [2:0] hold);
    logic [3:0] r;
    if (confirm) begin
      r = {1'b1, HOLD_INIT};
    end else if (frame && (hold != 3'd0)) begin
      r = {det && (hold != 3'd1), hold - 3'd1};
    end else begin
      r = {det, hold};
    end
    return r;
  endfunction

  logic         sync1_q, s_q, s_prev_q;
  logic [W-1:0] hp_cnt_q, hp_cnt_d;
  logic         armed_q, armed_d;
  cls_e         last_class_q, last_class_d;
  logic [2:0]   high_hold_q, high_hold_d, low_hold_q, low_hold_d;
  logic         high_det_q, high_det_d, low_det_q, low_det_d;
  logic         high_prev_q, low_prev_q;
  logic         high_start_q, low_start_q;

  logic edge_s, measure_s, conf_high_s, conf_low_s;
  cls_e meas_cls_s;

  // Classify the current count as a half-period and detect confirmations.
  always_comb begin
    edge_s    = s_q ^ s_prev_q;
    measure_s = edge_s & armed_q;
    if (abs_diff(hp_cnt_q, HIGH_HP) <= TOL_W) begin
      meas_cls_s = CLS_HIGH;
    end else if (abs_diff(hp_cnt_q, LOW_HP) <= TOL_W) begin
      meas_cls_s = CLS_LOW;
    end else begin
      meas_cls_s = CLS_NONE;
    end
    conf_high_s = measure_s && (meas_cls_s == CLS_HIGH) && (last_class_q == CLS_HIGH);
    conf_low_s  = measure_s && (meas_cls_s == CLS_LOW)  && (last_class_q == CLS_LOW);
  end

  // Next-state for the half-period counter, arming and class history.
  always_comb begin
    hp_cnt_d     = hp_cnt_q;
    armed_d      = armed_q;
    last_class_d = last_class_q;
    // An edge clears the counter even if a line strobe lands in the same cycle.
    if (edge_s) begin
      hp_cnt_d = {W{1'b0}};
    end else if (line_pulse && (hp_cnt_q != CNT_MAX)) begin
      hp_cnt_d = hp_cnt_q + W'(1);
    end else begin
      hp_cnt_d = hp_cnt_q;
    end
    if (edge_s) begin
      armed_d = 1'b1;
      if (armed_q) begin
        last_class_d = meas_cls_s;
      end else begin
        last_class_d = last_class_q;
      end
    end else if (hp_cnt_q == CNT_MAX) begin
      // Silence: forget the history so the next tone needs three edges again.
      armed_d      = 1'b0;
      last_class_d = CLS_NONE;
    end else begin
      armed_d      = armed_q;
      last_class_d = last_class_q;
    end
    {high_det_d, high_hold_d} = hold_next(conf_high_s, frame_pulse, high_det_q, high_hold_q);
    {low_det_d,  low_hold_d}  = hold_next(conf_low_s,  frame_pulse, low_det_q,  low_hold_q);
  end

  // State registers, synchronizer and start-pulse edge detectors.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_prev_q     <= 1'b0;
      hp_cnt_q     <= {W{1'b0}};
      armed_q      <= 1'b0;
      last_class_q <= CLS_NONE;
      high_hold_q  <= 3'd0;
      low_hold_q   <= 3'd0;
      high_det_q   <= 1'b0;
      low_det_q    <= 1'b0;
      high_prev_q  <= 1'b0;
      low_prev_q   <= 1'b0;
      high_start_q <= 1'b0;
      low_start_q  <= 1'b0;
    end else begin
      sync1_q      <= sound_in;
      s_q          <= sync1_q;
      s_prev_q     <= s_q;
      hp_cnt_q     <= hp_cnt_d;
      armed_q      <= armed_d;
      last_class_q <= last_class_d;
      high_hold_q  <= high_hold_d;
      low_hold_q   <= low_hold_d;
      high_det_q   <= high_det_d;
      low_det_q    <= low_det_d;
      high_prev_q  <= high_det_q;
      low_prev_q   <= low_det_q;
      high_start_q <= high_det_q & ~high_prev_q;
      low_start_q  <= low_det_q & ~low_prev_q;
    end
  end

  assign high_beep_det = high_det_q;
  assign low_beep_det  = low_det_q;
  assign high_start    = high_start_q;
  assign low_start     = low_start_q;

endmodule

// File: doc/p18_beep_detector.md
# p18_beep_detector

Receive-side counterpart of the p18 sound generator. It samples a square-wave audio line, measures the half-period in video-line units, and classifies the tone as the high beep (half-period 2^(SOUND_DIVIDER-1) lines) or the low beep (2^SOUND_DIVIDER lines). After confirmation it reports a frame-held presence flag per tone. It is used for sound loopback self-test and for a second board listening to the game's speaker line.

## Interface
- SOUND_DIVIDER, 5: tone divider exponent. Must match the generator. Legal values ≥ 3.
- TOLERANCE, 2: allowed ± deviation of the measured half-period, in lines. Must be < 2^(SOUND_DIVIDER-2).
- HOLD_FRAMES, 3: frames a detect flag stays set after the last confirmation. Legal range 1..7.
- clk  in  1  system clock
- nRst  in  1  reset, asynchronous, active-low
- sound_in  in  1  asynchronous audio square wave
- line_pulse  in  1  one-clk strobe per video line, synchronous to clk
- frame_pulse  in  1  one-clk strobe per frame, synchronous to clk
- high_beep_det  out  1  high tone present (held)
- low_beep_det  out  1  low tone present (held)
- high_start  out  1  one-clk pulse on rise of high_beep_det
- low_start  out  1  one-clk pulse on rise of low_beep_det

## Operation
- **Synchronizer:** sound_in passes through a 2-flop synchronizer into s_q. Register s_prev holds the previous s_q. An edge is recognized when s_q != s_prev; both polarities count.
- **Half-period counter hp_cnt:** width SOUND_DIVIDER+2. It increments on line_pulse and saturates at all-ones.
  - On an edge, hp_cnt is captured as m and cleared to 0.
  - The edge wins over a same-cycle line_pulse: the result is 0, not 1.
- **armed flag:**
  - Set by any edge.
  - Cleared when hp_cnt reaches saturation (silence). Clearing it also clears last_class.
  - An edge while unarmed only arms; it produces no measurement.
- **Classification** (edge while armed, using m):
  - HIGH when |m − 2^(SOUND_DIVIDER-1)| ≤ TOLERANCE.
  - LOW when |m − 2^SOUND_DIVIDER| ≤ TOLERANCE.
  - Otherwise NONE.
  - Compare in full counter width; no wrap is possible because the counter saturates.
- **Confirmation:**
  - If the class is HIGH/LOW and equals last_class, that tone is confirmed: its det flag is set and its hold counter (3 bits) is reloaded to HOLD_FRAMES.
  - last_class is updated to the class on every classification.
  - A NONE classification resets last_class to NONE.
- **Hold:** on frame_pulse, each nonzero hold counter decrements. The det flag clears in the same cycle its counter goes 1→0.
  - When a reload and a frame_pulse fall in the same cycle, the reload wins.
- **Start pulses:** high_start = high_beep_det & ~prev_high_det, registered. low_start is the same for the low tone.
- **Mixed waveform:** the generator's XOR of both tones toggles every 2^SOUND_DIVIDER lines, so it is classified LOW. high_beep_det is not asserted for the mixture.
- **Reset:** nRst low clears all registers asynchronously.
  - All outputs are 0, armed = 0, last_class = NONE, hold counters = 0, hp_cnt = 0.
  - Mid-detection reset discards progress; a new detection needs three fresh edges.

## Timing
- sound_in change in cycle t → s_q changes at t+2 → edge is recognized in cycle t+2.
- Det flag and hold counter update at the end of the recognition cycle, so det is visible at t+3.
- start pulse visible at t+4, lasting exactly 1 cycle.
- Detection latency: 3 edges (arm, measure, confirm), i.e. 2 half-periods after the first edge plus 3 clk.
- Edges of a line-aligned source measure exactly N for an N-line half-period, independent of the fixed synchronizer delay.
- Silence timeout: 2^(SOUND_DIVIDER+2)−1 line_pulses without an edge (127 at default) disarms.
- Det clear: on the HOLD_FRAMES-th frame_pulse after the last confirmation; visible the next cycle.

## Test plan
All scenarios use the defaults (HIGH = 16, LOW = 32, TOL = 2, HOLD = 3).
- **Reset:** nRst low with sound_in toggling → all outputs 0. Release, no edges → outputs stay 0.
- **High tone:** sound_in toggles every 16 line_pulses → high_beep_det = 1 at 3 clk after the third edge. high_start pulses for one cycle, one clk later. low outputs stay 0.
- **Low tone:** toggle every 32 lines → low_beep_det asserts after the third edge. Feed the generator's mixed XOR waveform → only low_beep_det.
- **Tolerance:** half-periods of 18 and 14 lines → high detected. 19, 24 and 29 lines → no detect.
- **Hold and silence:**
  - After high is detected, stop toggling → high_beep_det stays through 2 frame_pulses and clears after the 3rd.
  - A reload coinciding with a frame_pulse keeps the count at 3.
  - After 127 lines of silence, a single edge does not re-detect.
- **Mid-operation reset:** assert nRst between the second and third edge → no detect. The next detection needs 3 new edges.
